// File: rtl/pmem_burst_ctrl.sv
// Line-to-burst responder: turns each 256-bit pmem read/write line request into
// one burst command plus BEATS data beats on the narrower memory port.
module pmem_burst_ctrl #(
  parameter int unsigned BEAT_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pmem_read,
  input  logic                  pmem_write,
  input  logic [31:0]           pmem_address,
  input  logic [255:0]          pmem_wdata,
  output logic                  pmem_resp,
  output logic [255:0]          pmem_rdata,
  output logic                  mem_cmd_valid,
  input  logic                  mem_cmd_ready,
  output logic                  mem_cmd_write,
  output logic [31:0]           mem_cmd_addr,
  input  logic                  mem_rvalid,
  input  logic [BEAT_WIDTH-1:0] mem_rdata,
  output logic                  mem_wvalid,
  input  logic                  mem_wready,
  output logic [BEAT_WIDTH-1:0] mem_wdata,
  input  logic                  mem_bvalid
);

  localparam int unsigned LINE_W   = 256;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned OFFSET_W = 5;
  localparam int unsigned BEATS    = LINE_W / BEAT_WIDTH;
  localparam int unsigned BEAT_CW  = $clog2(BEATS);
  localparam int unsigned LOG_BW   = $clog2(BEAT_WIDTH);
  localparam int unsigned OFF_W    = BEAT_CW + LOG_BW;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    RDATA,
    WDATA,
    WACK,
    RESP,
    GAP
  } state_t;

  state_t              state;
  logic [BEAT_CW-1:0]  beat;
  logic [BEAT_CW-1:0]  beat_nxt;
  logic                last_beat;
  logic [LINE_W-1:0]   rline;
  logic [LINE_W-1:0]   wline;
  logic [LINE_W-1:0]   line_fill;
  logic [OFF_W-1:0]    rd_off;
  logic [OFF_W-1:0]    wr_off;
  logic                addr_unused;

  // Line offset bits carry no meaning on the burst port.
  assign addr_unused = ^pmem_address[OFFSET_W-1:0];

  assign beat_nxt  = beat + BEAT_CW'(1);
  assign last_beat = (beat == BEAT_CW'(BEATS - 1));
  assign rd_off    = {beat, LOG_BW'(0)};
  assign wr_off    = {beat_nxt, LOG_BW'(0)};

  // Read line with the current beat merged in, so the final beat lands in pmem_rdata.
  always_comb begin
    line_fill = rline;
    line_fill[rd_off +: BEAT_WIDTH] = mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      beat          <= '0;
      rline         <= '0;
      wline         <= '0;
      pmem_resp     <= 1'b0;
      pmem_rdata    <= '0;
      mem_cmd_valid <= 1'b0;
      mem_cmd_write <= 1'b0;
      mem_cmd_addr  <= '0;
      mem_wvalid    <= 1'b0;
      mem_wdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pmem_read || pmem_write) begin
            // Read has priority when both requests are raised together.
            mem_cmd_write <= ~pmem_read;
            mem_cmd_addr  <= {pmem_address[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
            if (!pmem_read) begin
              wline <= pmem_wdata;
            end
            beat          <= '0;
            mem_cmd_valid <= 1'b1;
            state         <= CMD;
          end
        end

        CMD: begin
          if (mem_cmd_ready) begin
            mem_cmd_valid <= 1'b0;
            if (mem_cmd_write) begin
              mem_wvalid <= 1'b1;
              mem_wdata  <= wline[BEAT_WIDTH-1:0];
              state      <= WDATA;
            end else begin
              state <= RDATA;
            end
          end
        end

        RDATA: begin
          if (mem_rvalid) begin
            rline[rd_off +: BEAT_WIDTH] <= mem_rdata;
            beat                        <= beat_nxt;
            if (last_beat) begin
              pmem_rdata <= line_fill;
              pmem_resp  <= 1'b1;
              state      <= RESP;
            end
          end
        end

        WDATA: begin
          if (mem_wready) begin
            beat <= beat_nxt;
            if (last_beat) begin
              mem_wvalid <= 1'b0;
              state      <= WACK;
            end else begin
              mem_wdata <= wline[wr_off +: BEAT_WIDTH];
            end
          end
        end

        WACK: begin
          if (mem_bvalid) begin
            pmem_resp <= 1'b1;
            state     <= RESP;
          end
        end

        RESP: begin
          pmem_resp <= 1'b0;
          state     <= GAP;
        end

        // Dead cycle so the initiator's request has dropped before IDLE samples again.
        GAP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_burst_ctrl.sv
// Scoreboard bench for pmem_burst_ctrl: stimulus pushes expected commands, write
// beats and line responses; a monitor pops and compares as the DUT presents them.
module tb_pmem_burst_ctrl;

  localparam int BW = 64;

  typedef struct {
    logic [255:0] data;
    int           cyc;
  } resp_t;

  logic           clk = 1'b0;
  logic           reset;
  logic           pmem_read;
  logic           pmem_write;
  logic [31:0]    pmem_address;
  logic [255:0]   pmem_wdata;
  logic           pmem_resp;
  logic [255:0]   pmem_rdata;
  logic           mem_cmd_valid;
  logic           mem_cmd_ready;
  logic           mem_cmd_write;
  logic [31:0]    mem_cmd_addr;
  logic           mem_rvalid;
  logic [BW-1:0]  mem_rdata;
  logic           mem_wvalid;
  logic           mem_wready;
  logic [BW-1:0]  mem_wdata;
  logic           mem_bvalid;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  resp_t          exp_resp[$];
  logic [32:0]    exp_cmd[$];
  logic [BW-1:0]  exp_wbeat[$];
  logic [255:0]   last_rline;
  resp_t          mon_e;
  logic [32:0]    mon_c;

  pmem_burst_ctrl #(.BEAT_WIDTH(BW)) dut (
    .clk           (clk),
    .reset         (reset),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_address  (pmem_address),
    .pmem_wdata    (pmem_wdata),
    .pmem_resp     (pmem_resp),
    .pmem_rdata    (pmem_rdata),
    .mem_cmd_valid (mem_cmd_valid),
    .mem_cmd_ready (mem_cmd_ready),
    .mem_cmd_write (mem_cmd_write),
    .mem_cmd_addr  (mem_cmd_addr),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .mem_wvalid    (mem_wvalid),
    .mem_wready    (mem_wready),
    .mem_wdata     (mem_wdata),
    .mem_bvalid    (mem_bvalid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic flag(input string name);
    n_total++;
    $display("FAIL %s: got unexpected event, required none", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every DUT-presented response, command handshake and write beat.
  always @(negedge clk) begin
    if (!reset) begin
      if (pmem_resp) begin
        if (exp_resp.size() == 0) flag("resp_unexpected");
        else begin
          mon_e = exp_resp.pop_front();
          chk("resp_rdata", pmem_rdata, mon_e.data);
          chk("resp_cycle", 256'(cyc), 256'(mon_e.cyc));
        end
      end
      if (mem_cmd_valid && mem_cmd_ready) begin
        if (exp_cmd.size() == 0) flag("cmd_unexpected");
        else begin
          mon_c = exp_cmd.pop_front();
          chk("cmd_write_addr", {mem_cmd_write, mem_cmd_addr}, mon_c);
        end
      end
      if (mem_wvalid) begin
        if (exp_wbeat.size() == 0) flag("wbeat_unexpected");
        else begin
          chk("wbeat_data", mem_wdata, exp_wbeat[0]);
          if (mem_wready) void'(exp_wbeat.pop_front());
        end
      end
    end
  end

  task automatic clear_inputs();
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_address  = '0;
    pmem_wdata    = '0;
    mem_cmd_ready = 1'b0;
    mem_rvalid    = 1'b0;
    mem_rdata     = '0;
    mem_wready    = 1'b0;
    mem_bvalid    = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_resp"},      pmem_resp, 0);
    chk({tag, "_rdata"},     pmem_rdata, 0);
    chk({tag, "_cmd_valid"}, mem_cmd_valid, 0);
    chk({tag, "_cmd_write"}, mem_cmd_write, 0);
    chk({tag, "_cmd_addr"},  mem_cmd_addr, 0);
    chk({tag, "_wvalid"},    mem_wvalid, 0);
    chk({tag, "_wdata"},     mem_wdata, 0);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_resp.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (exp_resp.size() != 0) begin
      $display("FAIL resp_timeout: got %0d pending, required 0", exp_resp.size());
      n_total++;
      exp_resp.delete();
    end
  endtask

  // Line read; cmd_stall cycles of cmd_ready low with stray rvalid pulses; hold keeps pmem_read through GAP.
  task automatic do_read(input logic [31:0] addr, input logic [255:0] line,
                         input int cmd_stall, input bit hold, input bit with_write);
    int t0;
    resp_t e;
    t0           = cyc;
    pmem_read    = 1'b1;
    pmem_write   = with_write;
    pmem_address = addr;
    pmem_wdata   = ~line;
    exp_cmd.push_back({1'b0, addr[31:5], 5'b0});
    e.data = line;
    e.cyc  = t0 + 6 + cmd_stall;
    exp_resp.push_back(e);
    last_rline = line;
    step();
    for (int i = 0; i < cmd_stall; i++) begin
      mem_cmd_ready = 1'b0;
      mem_rvalid    = (i % 2 == 1);
      mem_rdata     = {BW/4{4'hE}};
      @(negedge clk);
      chk("cmd_valid_stall", mem_cmd_valid, 1);
      step();
    end
    mem_cmd_ready = 1'b1;
    mem_rvalid    = 1'b0;
    step();
    mem_cmd_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = BW'(line >> (b * BW));
      step();
    end
    mem_rvalid = 1'b0;
    step();
    if (hold) step();
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    wait_drain();
    repeat (3) step();
  endtask

  // Line write with wready toggling 1,0,1,0... and bvalid three cycles into WACK.
  task automatic do_write(input logic [31:0] addr, input logic [255:0] line);
    int t0;
    resp_t e;
    t0           = cyc;
    pmem_write   = 1'b1;
    pmem_address = addr;
    pmem_wdata   = line;
    exp_cmd.push_back({1'b1, addr[31:5], 5'b0});
    for (int b = 0; b < 4; b++) exp_wbeat.push_back(BW'(line >> (b * BW)));
    e.data = last_rline;
    e.cyc  = t0 + 13;
    exp_resp.push_back(e);
    step();
    mem_cmd_ready = 1'b1;
    step();
    mem_cmd_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      mem_wready = (i % 2 == 0);
      step();
    end
    mem_wready = 1'b0;
    repeat (3) step();
    mem_bvalid = 1'b1;
    step();
    mem_bvalid = 1'b0;
    step();
    pmem_write = 1'b0;
    wait_drain();
    chk("wbeats_left", 256'(exp_wbeat.size()), 0);
    repeat (3) step();
  endtask

  task automatic reset_mid_read();
    pmem_read    = 1'b1;
    pmem_address = 32'h0000_4000;
    exp_cmd.push_back({1'b0, 32'h0000_4000});
    step();
    mem_cmd_ready = 1'b1;
    step();
    mem_cmd_ready = 1'b0;
    mem_rvalid    = 1'b1;
    mem_rdata     = {BW/4{4'h9}};
    step();
    mem_rdata     = {BW/4{4'h8}};
    step();
    reset         = 1'b1;
    pmem_read     = 1'b0;
    mem_rdata     = {BW/4{4'h7}};
    step();
    reset         = 1'b0;
    mem_rdata     = {BW/4{4'h6}};
    @(negedge clk);
    check_zero("rst_mid");
    step();
    mem_rvalid = 1'b0;
    last_rline = '0;
    repeat (3) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    last_rline = '0;
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_zero("rst_init");
    step();
    reset = 1'b0;
    step();

    do_read(32'h0000_1234,
            {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 0, 1'b0, 1'b0);
    do_write(32'h0000_2040,
             {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}});
    do_read(32'h8000_00FF,
            {64'hFEEDFACE_00000004, 64'h0BADC0DE_00000003,
             64'hCAFEF00D_00000002, 64'hDEADBEEF_00000001}, 5, 1'b0, 1'b0);
    do_read(32'h0001_0020,
            {64'h5A5A_A5A5_0F0F_F0F3, 64'h5A5A_A5A5_0F0F_F0F2,
             64'h5A5A_A5A5_0F0F_F0F1, 64'h5A5A_A5A5_0F0F_F0F0}, 0, 1'b1, 1'b0);
    reset_mid_read();
    do_read(32'h0000_4000,
            {{16{4'h5}}, {16{4'h3}}, {16{4'hF}}, {16{4'h0}}}, 0, 1'b0, 1'b0);
    do_read(32'hFFFF_FFE7,
            {64'h4, 64'h3, 64'h2, 64'h1}, 0, 1'b0, 1'b1);

    repeat (5) step();
    chk("cmd_left",  256'(exp_cmd.size()), 0);
    chk("resp_left", 256'(exp_resp.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pmem_burst_ctrl.md
# pmem_burst_ctrl

Physical-memory responder that terminates the 256-bit line protocol driven by the L2 arbiter: pmem_read/pmem_write, pmem_address, pmem_wdata in; pmem_resp, pmem_rdata out. Each line transaction becomes one command plus BEATS data beats on a narrower burst memory port. Read beats are assembled into a line, write lines are split into beats, and the block returns exactly one single-cycle pmem_resp per transaction. It sits between the L2 arbiter and the off-chip memory model/controller.

## Interface
- BEAT_WIDTH, 64, burst data width; legal values 32, 64, 128. BEATS = 256/BEAT_WIDTH.
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- pmem_read  in  1  line read request; held high until pmem_resp
- pmem_write  in  1  line write request; held high until pmem_resp
- pmem_address  in  32  line address; bits [4:0] ignored
- pmem_wdata  in  256  write line; stable while pmem_write high
- pmem_resp  out  1  one-cycle completion strobe
- pmem_rdata  out  256  read line; valid in the pmem_resp cycle, held until the next read completes
- mem_cmd_valid  out  1  command valid
- mem_cmd_ready  in  1  command accepted when valid&ready
- mem_cmd_write  out  1  1 = write burst, 0 = read burst
- mem_cmd_addr  out  32  {pmem_address[31:5], 5'b0}
- mem_rvalid  in  1  read beat valid; no backpressure
- mem_rdata  in  BEAT_WIDTH  read beat
- mem_wvalid  out  1  write beat valid
- mem_wready  in  1  write beat accepted when wvalid&wready
- mem_wdata  out  BEAT_WIDTH  write beat
- mem_bvalid  in  1  write burst acknowledge

## Operation
- States: IDLE, CMD, RDATA, WDATA, WACK, RESP, GAP.
- IDLE: on pmem_read or pmem_write, latch address (and pmem_wdata on a write) into internal registers and go to CMD. If both are high, the read wins.
- CMD: mem_cmd_valid=1. mem_cmd_write and mem_cmd_addr come from the latched request. On mem_cmd_ready, go to RDATA for a read or WDATA for a write.
- RDATA: each mem_rvalid writes mem_rdata into line buffer bits [beat*BEAT_WIDTH +: BEAT_WIDTH], then increments beat. Beat 0 is the least significant. On beat == BEATS-1 with rvalid, go to RESP.
- WDATA: mem_wvalid=1 and mem_wdata = latched line slice [beat*BEAT_WIDTH +: BEAT_WIDTH]. On wready, increment beat. On the last beat, go to WACK.
- WACK: wait for mem_bvalid, then go to RESP.
- RESP: pmem_resp=1 for exactly one cycle; pmem_rdata is driven from the line buffer. Then go to GAP.
- GAP: one dead cycle; requests are ignored. This guarantees the initiator has dropped the request before IDLE re-samples it. Then go to IDLE.
- The beat counter is log2(BEATS) bits, is cleared on CMD entry, and wraps only on the last beat.
- mem_rvalid outside RDATA, mem_bvalid outside WACK, and mem_wready outside WDATA are ignored.
- A write never modifies the read line buffer. pmem_rdata is unchanged after a write completes.
- Reset, at any time: state=IDLE, beat=0, line buffer=0. All outputs are 0 (pmem_resp, pmem_rdata, mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_wvalid, mem_wdata). An in-flight burst is abandoned, and trailing lower-side beats and acks are ignored by rule above.

## Timing
- Request is sampled in IDLE (cycle 0); mem_cmd_valid is high in cycle 1.
- Read with zero-wait memory and BEATS=4: cmd accepted in cycle 1, beats in cycles 2–5, pmem_resp in cycle 6, GAP in cycle 7, IDLE in cycle 8.
- Write with zero-wait memory and BEATS=4: beats in cycles 2–5, WACK in cycle 6 with bvalid, pmem_resp in cycle 7.
- Latency grows by one cycle per cycle of mem_cmd_ready low, per rvalid gap, per wready stall, and per bvalid delay.
- Minimum spacing between pmem_resp strobes: read 8 cycles, write 9 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Test plan
- Read with zero-wait memory, BEAT_WIDTH=64, address 0x0000_1234, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> mem_cmd_addr=0x0000_1220, mem_cmd_write=0. pmem_resp high only in cycle 6, with pmem_rdata = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write of line 0xDDDD..CCCC..BBBB..AAAA with wready toggling 1,0,1,0… -> mem_wdata beats AAAA.., BBBB.., CCCC.., DDDD.. in order, each held through its stall. With bvalid 3 cycles after WACK entry, pmem_resp follows one cycle later, and pmem_rdata is unchanged.
- mem_cmd_ready held low 5 cycles, plus mem_rvalid pulses arriving while in CMD -> the early beats are ignored, mem_cmd_valid stays high, and pmem_resp comes 5 cycles later than the zero-wait case.
- pmem_read kept high through RESP and GAP -> exactly one mem_cmd_valid handshake and exactly one pmem_resp per request.
- reset asserted after beat 2 of a read, with 2 trailing rvalid beats -> all outputs 0 the next cycle. The trailing beats are ignored, and the next read returns only its own data.
- pmem_read and pmem_write asserted together -> a read command is issued (mem_cmd_write=0).
